// File: rtl/arb_pkg.sv
// Shared types and width helpers for the round-robin arbiter.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } arb_state_t;

   localparam int DEFAULT_N        = 4;
   localparam int DEFAULT_MAX_HOLD = 16;

   // Bits needed to index n items. A single item still needs one bit.
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEFAULT_PTR_W = width_of(DEFAULT_N);
   localparam int DEFAULT_CNT_W = width_of(DEFAULT_MAX_HOLD);

endpackage

// File: rtl/rr_arbiter_pick.sv
// Rotating-priority picker: finds the first set request at or above ptr,
// wrapping modulo N.
module rr_pick
   import arb_pkg::*;
#(
   parameter int N  = DEFAULT_N,
   parameter int PW = width_of(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          valid,
   output logic [PW-1:0] idx,
   output logic [N-1:0]  sel
);

   logic [PW-1:0] cand;

   // Scan from ptr upward; the first hit wins and later hits are ignored.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      sel   = '0;
      cand  = '0;
      for (int i = 0; i < N; i++) begin
         cand = PW'((int'(ptr) + i) % N);
         if (!valid && req[cand]) begin
            valid     = 1'b1;
            idx       = cand;
            sel       = '0;
            sel[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with IDLE/GRANT/RELEASE control, a hold limit and a
// one-cycle turnaround between grants.
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int N        = DEFAULT_N,
   parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
   input  logic                 clock,
   input  logic                 n_reset,
   input  logic [N-1:0]         req,
   input  logic                 done,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] owner,
   output logic                 busy,
   output logic                 timeout
);

   localparam int PW = width_of(N);
   localparam int CW = width_of(MAX_HOLD);

   arb_state_t    state_q, state_d;
   logic [N-1:0]  grant_q, grant_d;
   logic [PW-1:0] owner_q, owner_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          timeout_q, timeout_d;

   logic          pick_valid;
   logic [PW-1:0] pick_idx;
   logic [N-1:0]  pick_sel;
   logic          at_limit;
   logic          owner_req;

   rr_pick #(
      .N  (N),
      .PW (PW)
   ) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx),
      .sel   (pick_sel)
   );

   assign at_limit  = (cnt_q == CW'(MAX_HOLD - 1));
   assign owner_req = req[owner_q];

   // Next-state logic: grant entry, release causes, pointer rotation.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            grant_d = '0;
            if (pick_valid) begin
               state_d = GRANT;
               grant_d = pick_sel;
               owner_d = pick_idx;
               cnt_d   = '0;
            end
         end
         GRANT: begin
            if (done || !owner_req || at_limit) begin
               state_d   = RELEASE;
               grant_d   = '0;
               ptr_d     = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;
               timeout_d = at_limit && !done && owner_req;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RELEASE: begin
            grant_d = '0;
            if (pick_valid) begin
               state_d = GRANT;
               grant_d = pick_sel;
               owner_d = pick_idx;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State, counter, pointer and registered outputs.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         owner_q   <= '0;
         ptr_q     <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign grant   = grant_q;
   assign owner   = owner_q;
   assign busy    = (state_q == GRANT);
   assign timeout = timeout_q;

endmodule
